sqed_regfile_tracker: RTL and testbench

//  Parametrised register file with built-in SQED self-consistency tracking, for the formal/sim harness of the RISC-V core.
//  The lower half of the register file holds original state; the upper half holds the duplicate (shadow) state.
//  The block counts committed original and duplicate writes and runs a 4-state tracking FSM.

---
 rtl/sqed_regfile_tracker_pkg.sv | 15 +
 rtl/sqed_pair_cmp.sv | 30 +++
 rtl/sqed_regfile_tracker.sv | 143 ++++++++++++++
 tb/tb_sqed_regfile_tracker.sv | 193 +++++++++++++++++++
 4 files changed

// File: rtl/sqed_regfile_tracker_pkg.sv
// rtl/sqed_regfile_tracker_pkg.sv - shared types and helpers for the SQED register-file tracker
package sqed_regfile_tracker_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    TRACK = 2'd1,
    READY = 2'd2,
    FAIL  = 2'd3
  } state_e;

  function automatic int half_of(input int nregs);
    return nregs / 2;
  endfunction

endpackage

// File: rtl/sqed_pair_cmp.sv
// rtl/sqed_pair_cmp.sv - masked original/duplicate pair comparator with lowest-index encoder
module sqed_pair_cmp #(
  parameter int XLEN = 32,
  parameter int HALF = 16
) (
  input  logic [2*HALF*XLEN-1:0] v_flat,
  input  logic [HALF-1:0]        pair_en,
  output logic [HALF-1:0]        pair_mism,
  output logic [$clog2(HALF)-1:0] low_idx
);

  localparam int IW = $clog2(HALF);

  always_comb begin
    pair_mism = '0;
    for (int i = 0; i < HALF; i++) begin
      pair_mism[i] = pair_en[i] &&
                     (v_flat[i*XLEN +: XLEN] != v_flat[(i+HALF)*XLEN +: XLEN]);
    end
  end

  // Scan downwards so the lowest failing index wins.
  always_comb begin
    low_idx = '0;
    for (int i = HALF - 1; i >= 0; i--) begin
      if (pair_mism[i]) low_idx = IW'(i);
    end
  end

endmodule

// File: rtl/sqed_regfile_tracker.sv
// rtl/sqed_regfile_tracker.sv - register file with SQED original/duplicate consistency tracking
module sqed_regfile_tracker
  import sqed_regfile_tracker_pkg::*;
#(
  parameter int XLEN       = 32,
  parameter int NREGS      = 32,
  parameter int CNT_W      = 16,
  parameter int CHECK_MODE = 1,
  parameter int CHECK_REG  = 1
) (
  input  logic                       clk,
  input  logic                       outside_reset,
  input  logic                       reg_write,
  input  logic                       qed_vld_out_ex_mem,
  input  logic [$clog2(NREGS)-1:0]   read_reg1,
  input  logic [$clog2(NREGS)-1:0]   read_reg2,
  input  logic [$clog2(NREGS)-1:0]   write_reg,
  input  logic [XLEN-1:0]            write_data,
  output logic [XLEN-1:0]            read_data1,
  output logic [XLEN-1:0]            read_data2,
  output logic                       qed_ready,
  output logic                       qed_check,
  output logic                       qed_mismatch,
  output logic                       qed_init_bad,
  output logic [$clog2(NREGS)-2:0]   qed_fail_idx,
  output logic                       qed_sat,
  output logic [CNT_W-1:0]           num_orig_insts,
  output logic [CNT_W-1:0]           num_dup_insts
);

  localparam int AW   = $clog2(NREGS);
  localparam int HALF = half_of(NREGS);
  localparam int HW   = AW - 1;
  localparam logic [HALF-1:0] ALL_MASK = ~(HALF'(1));
  localparam logic [HALF-1:0] SEL_MASK = (CHECK_MODE == 0) ? (HALF'(1) << CHECK_REG) : ALL_MASK;

  logic [XLEN-1:0]        regs_q [NREGS];
  logic [XLEN-1:0]        regs_d [NREGS];
  logic [CNT_W-1:0]       orig_q, orig_d, dup_q, dup_d;
  state_e                 state_q, state_d;
  logic                   mismatch_q, mismatch_d;
  logic                   init_bad_q, init_bad_d;
  logic                   sat_q, sat_d;
  logic [HW-1:0]          fail_idx_q, fail_idx_d;

  logic                   wr_en, commit, orig_commit, dup_commit;
  logic                   ready_next, fail_now, any_mism;
  logic [2*HALF*XLEN-1:0] v_flat;
  logic [HALF-1:0]        cmp_mask, pair_mism;
  logic [HW-1:0]          low_idx;

  // regs_d is the file with this cycle's write applied: it is both the bypass
  // read view and the compare view.
  always_comb begin
    wr_en  = reg_write && (write_reg != '0);
    regs_d = regs_q;
    if (wr_en) regs_d[write_reg] = write_data;
    v_flat = '0;
    for (int i = 0; i < NREGS; i++) v_flat[i*XLEN +: XLEN] = regs_d[i];
  end

  assign read_data1 = (read_reg1 == '0) ? '0 : regs_d[read_reg1];
  assign read_data2 = (read_reg2 == '0) ? '0 : regs_d[read_reg2];

  // Init check (IDLE) and READY check never coincide, so one comparator serves both.
  assign cmp_mask = (state_q == IDLE) ? ALL_MASK : SEL_MASK;

  sqed_pair_cmp #(.XLEN(XLEN), .HALF(HALF)) u_cmp (
    .v_flat    (v_flat),
    .pair_en   (cmp_mask),
    .pair_mism (pair_mism),
    .low_idx   (low_idx)
  );

  assign any_mism = |pair_mism;

  always_comb begin
    commit      = qed_vld_out_ex_mem && reg_write;
    orig_commit = commit && wr_en && !write_reg[AW-1];
    dup_commit  = commit && write_reg[AW-1];
    orig_d      = orig_q + CNT_W'(orig_commit && (orig_q != '1));
    dup_d       = dup_q + CNT_W'(dup_commit && (dup_q != '1));
    ready_next  = (orig_d == dup_d) && (orig_d != '0);
    sat_d       = sat_q || (orig_d == '1) || (dup_d == '1);
    qed_ready   = (orig_q == dup_q) && (orig_q != '0);
    qed_check   = (state_q == READY) && qed_ready && qed_vld_out_ex_mem && !sat_q;
    fail_now    = qed_check && any_mism;
  end

  always_comb begin
    state_d    = state_q;
    init_bad_d = init_bad_q;
    mismatch_d = mismatch_q || fail_now;
    fail_idx_d = (fail_now && !mismatch_q) ? low_idx : fail_idx_q;
    case (state_q)
      IDLE: begin
        if (commit) begin
          init_bad_d = init_bad_q || any_mism;
          state_d    = TRACK;
        end
      end
      TRACK:   if (ready_next) state_d = READY;
      READY:   if (!ready_next) state_d = TRACK;
      FAIL:    state_d = FAIL;
      default: state_d = IDLE;
    endcase
    if (fail_now) state_d = FAIL;
  end

  always_ff @(posedge clk or posedge outside_reset) begin
    if (outside_reset) begin
      for (int i = 0; i < NREGS; i++) regs_q[i] <= XLEN'(i % HALF);
      orig_q     <= '0;
      dup_q      <= '0;
      state_q    <= IDLE;
      mismatch_q <= 1'b0;
      init_bad_q <= 1'b0;
      sat_q      <= 1'b0;
      fail_idx_q <= '0;
    end else begin
      regs_q     <= regs_d;
      orig_q     <= orig_d;
      dup_q      <= dup_d;
      state_q    <= state_d;
      mismatch_q <= mismatch_d;
      init_bad_q <= init_bad_d;
      sat_q      <= sat_d;
      fail_idx_q <= fail_idx_d;
    end
  end

  assign qed_mismatch   = mismatch_q;
  assign qed_init_bad   = init_bad_q;
  assign qed_fail_idx   = fail_idx_q;
  assign qed_sat        = sat_q;
  assign num_orig_insts = orig_q;
  assign num_dup_insts  = dup_q;

`ifdef FORMAL
  assert property (@(posedge clk) disable iff (outside_reset) (!qed_check || !fail_now));
`endif

endmodule

// File: tb/tb_sqed_regfile_tracker.sv
// tb/tb_sqed_regfile_tracker.sv - self-checking bench for sqed_regfile_tracker
module tb_sqed_regfile_tracker;
  import sqed_regfile_tracker_pkg::*;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        reg_write = 1'b0, qed_vld = 1'b0;
  logic [4:0]  read_reg1 = '0, read_reg2 = '0, write_reg = '0;
  logic [31:0] write_data = '0;

  logic [31:0] read_data1, read_data2, b_rd1, b_rd2;
  logic        qed_ready, qed_check, qed_mismatch, qed_init_bad, qed_sat;
  logic [3:0]  qed_fail_idx, b_fail_idx;
  logic [15:0] num_orig, num_dup;
  logic        b_ready, b_check, b_mismatch, b_init_bad, b_sat;
  logic [1:0]  b_orig, b_dup;

  always #5 clk = ~clk;

  sqed_regfile_tracker dut (
    .clk(clk), .outside_reset(rst), .reg_write(reg_write), .qed_vld_out_ex_mem(qed_vld),
    .read_reg1(read_reg1), .read_reg2(read_reg2), .write_reg(write_reg), .write_data(write_data),
    .read_data1(read_data1), .read_data2(read_data2), .qed_ready(qed_ready), .qed_check(qed_check),
    .qed_mismatch(qed_mismatch), .qed_init_bad(qed_init_bad), .qed_fail_idx(qed_fail_idx),
    .qed_sat(qed_sat), .num_orig_insts(num_orig), .num_dup_insts(num_dup)
  );

  sqed_regfile_tracker #(.CNT_W(2)) dut_b (
    .clk(clk), .outside_reset(rst), .reg_write(reg_write), .qed_vld_out_ex_mem(qed_vld),
    .read_reg1(read_reg1), .read_reg2(read_reg2), .write_reg(write_reg), .write_data(write_data),
    .read_data1(b_rd1), .read_data2(b_rd2), .qed_ready(b_ready), .qed_check(b_check),
    .qed_mismatch(b_mismatch), .qed_init_bad(b_init_bad), .qed_fail_idx(b_fail_idx),
    .qed_sat(b_sat), .num_orig_insts(b_orig), .num_dup_insts(b_dup)
  );

  int nvec = 0;
  int nmis = 0;

  // Reference model: plain arrays of values and counts, one entry per instance.
  logic [31:0] mreg [32];
  int          mco [2], mcd [2], midx [2];
  state_e      mst [2];
  bit          mmis [2], mbad [2], msat [2];
  int          cmax [2] = '{65535, 3};

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    nvec++;
    assert (obs === exp) else begin
      nmis++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic void model_reset();
    for (int i = 0; i < 32; i++) mreg[i] = 32'(i % 16);
    for (int k = 0; k < 2; k++) begin
      mco[k] = 0; mcd[k] = 0; mst[k] = IDLE; mmis[k] = 0;
      mbad[k] = 0; msat[k] = 0; midx[k] = 0;
    end
  endfunction

  task automatic check_regs();
    chk("orig_a", num_orig, mco[0]);
    chk("dup_a", num_dup, mcd[0]);
    chk("ready_a", qed_ready, (mco[0] == mcd[0]) && (mco[0] != 0));
    chk("mismatch_a", qed_mismatch, mmis[0]);
    chk("init_bad_a", qed_init_bad, mbad[0]);
    chk("fail_idx_a", qed_fail_idx, midx[0]);
    chk("sat_a", qed_sat, msat[0]);
    chk("state_a", dut.state_q, mst[0]);
    chk("orig_b", b_orig, mco[1]);
    chk("dup_b", b_dup, mcd[1]);
    chk("sat_b", b_sat, msat[1]);
    chk("mismatch_b", b_mismatch, mmis[1]);
    chk("state_b", dut_b.state_q, mst[1]);
  endtask

  task automatic cycle(input bit rw, input bit vld, input int wr, input logic [31:0] wd,
                       input int r1, input int r2);
    logic [31:0] v [32];
    bit comm, oc, dc, rdy, chkf, anym, nr;
    int low, nco, ncd;
    reg_write = rw; qed_vld = vld; write_reg = 5'(wr); write_data = wd;
    read_reg1 = 5'(r1); read_reg2 = 5'(r2);
    #2;
    v = mreg;
    if (rw && wr != 0) v[wr] = wd;
    chk("rd1", read_data1, v[r1]);
    chk("rd2", read_data2, v[r2]);
    low = 0;
    for (int i = 15; i >= 1; i--) if (v[i] != v[i+16]) low = i;
    anym = (low != 0);
    comm = vld && rw;
    oc = comm && wr != 0 && wr < 16;
    dc = comm && wr >= 16;
    for (int k = 0; k < 2; k++) begin
      rdy  = (mco[k] == mcd[k]) && (mco[k] != 0);
      chkf = (mst[k] == READY) && rdy && vld && !msat[k];
      if (k == 0) chk("check_a", qed_check, chkf);
      else        chk("check_b", b_check, chkf);
      nco = (oc && mco[k] < cmax[k]) ? mco[k] + 1 : mco[k];
      ncd = (dc && mcd[k] < cmax[k]) ? mcd[k] + 1 : mcd[k];
      nr  = (nco == ncd) && (nco != 0);
      if (mst[k] == IDLE && comm) begin
        if (anym) mbad[k] = 1;
        mst[k] = TRACK;
      end else if (mst[k] == TRACK && nr) mst[k] = READY;
      else if (mst[k] == READY && !nr) mst[k] = TRACK;
      if (chkf && anym) begin
        mst[k] = FAIL;
        if (!mmis[k]) midx[k] = low;
        mmis[k] = 1;
      end
      mco[k] = nco; mcd[k] = ncd;
      if (nco == cmax[k] || ncd == cmax[k]) msat[k] = 1;
    end
    mreg = v;
    @(posedge clk); #1;
    check_regs();
  endtask

  // Asserted away from the clock edge so the async clear is observed before any edge.
  task automatic do_reset();
    reg_write = 0; qed_vld = 0; write_reg = 0; write_data = 0;
    read_reg1 = 5; read_reg2 = 21;
    #2; rst = 1; #1;
    model_reset();
    check_regs();
    chk("rst_rd_x5", read_data1, 32'd5);
    chk("rst_rd_x21", read_data2, 32'd5);
    @(posedge clk); #1; rst = 0;
  endtask

  initial begin
    int wr;
    logic [31:0] wd;
    do_reset();
    cycle(0, 0, 0, 0, 0, 3);
    chk("x0_reads_zero", read_data1, 32'd0);

    // Matching pair x1/x17, then a checked commit.
    cycle(1, 1, 1, 32'hAA, 1, 17);
    cycle(1, 1, 17, 32'hAA, 1, 17);
    chk("ready_after_pair", qed_ready, 1'b1);
    cycle(0, 1, 0, 0, 1, 17);
    chk("no_mismatch", qed_mismatch, 1'b0);

    // Bypass on x9 and x25, then a write to x0 that must not count.
    cycle(1, 0, 9, 32'h1234, 9, 25);
    cycle(1, 0, 25, 32'h1234, 9, 25);
    cycle(1, 1, 0, 32'hFFFF, 0, 9);
    chk("x0_write_ignored", read_data1, 32'd0);

    // Fault on pair 3.
    cycle(1, 1, 3, 32'd7, 3, 19);
    cycle(1, 1, 19, 32'd8, 3, 19);
    cycle(1, 1, 2, 32'd2, 2, 18);
    chk("fail_idx_3", qed_fail_idx, 4'd3);
    chk("state_fail", dut.state_q, FAIL);
    cycle(1, 1, 3, 32'd8, 3, 19);
    cycle(1, 1, 19, 32'd8, 3, 19);
    cycle(0, 1, 0, 0, 3, 19);
    chk("mismatch_sticky", qed_mismatch, 1'b1);

    // Async reset while in FAIL, then a clean init check.
    do_reset();
    cycle(1, 1, 5, 32'd5, 5, 21);
    chk("init_ok_after_reset", qed_init_bad, 1'b0);

    // Saturation of the 2-bit counters in dut_b.
    do_reset();
    for (int i = 1; i <= 4; i++) cycle(1, 1, i, 32'(i), i, i + 16);
    chk("sat_hold_3", b_orig, 2'd3);
    chk("sat_flag", b_sat, 1'b1);
    for (int i = 1; i <= 3; i++) cycle(1, 1, i + 16, 32'(i), i, i + 16);
    cycle(0, 1, 0, 0, 1, 2);

    // Randomised traffic, with partner-value writes to keep pairs mostly equal.
    for (int blk = 0; blk < 3; blk++) begin
      do_reset();
      for (int n = 0; n < 80; n++) begin
        wr = int'($urandom_range(0, 31));
        wd = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 7)) : mreg[wr ^ 16];
        cycle($urandom_range(0, 3) != 0, $urandom_range(0, 1) == 1, wr, wd,
              int'($urandom_range(0, 31)), int'($urandom_range(0, 31)));
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
    $finish;
  end

endmodule
